// File: rtl/cr16_controller.sv
// cr16_controller
//
// Control sequencer for cr16_datapath. Fetches 16-bit instructions from a
// synchronous instruction memory, decodes them, and issues one datapath
// operation per instruction using a FETCH -> DECODE -> EXECUTE loop
// (3 cycles per instruction). Conditional branches use the registered
// datapath status flags; the all-ones instruction halts the sequencer
// until reset.
//
// Ports:
//   I_CLK               system clock, rising-edge active
//   I_NRESET            asynchronous active-low reset
//   I_ENABLE            global enable; 0 stalls state, PC and IR
//   I_INSTRUCTION       instruction memory read data (valid the cycle after O_MEM_READ)
//   I_STATUS_FLAGS      datapath flags [0]=C [1]=L [2]=F [3]=Z [4]=N
//   O_PC                instruction address
//   O_MEM_READ          instruction memory read strobe
//   O_REG_WRITE_ENABLE  one-hot register write enable (EXECUTE only)
//   O_REG_A_SELECT      datapath port A register index
//   O_REG_B_SELECT      datapath port B register index
//   O_OPCODE            datapath ALU opcode
//   O_IMMEDIATE         immediate value to the datapath
//   O_IMMEDIATE_SELECT  1 selects O_IMMEDIATE as operand B
//   O_HALTED            1 while in HALT
module cr16_controller #(
    parameter int                  PC_WIDTH  = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [3:0]          ALU_ADD   = 4'b0101,
    parameter logic [3:0]          ALU_PASSB = 4'b1101
) (
    input  logic                I_CLK,
    input  logic                I_NRESET,
    input  logic                I_ENABLE,
    input  logic [15:0]         I_INSTRUCTION,
    input  logic [4:0]          I_STATUS_FLAGS,
    output logic [PC_WIDTH-1:0] O_PC,
    output logic                O_MEM_READ,
    output logic [15:0]         O_REG_WRITE_ENABLE,
    output logic [3:0]          O_REG_A_SELECT,
    output logic [3:0]          O_REG_B_SELECT,
    output logic [3:0]          O_OPCODE,
    output logic [15:0]         O_IMMEDIATE,
    output logic                O_IMMEDIATE_SELECT,
    output logic                O_HALTED
);

    localparam logic [1:0] S_FETCH   = 2'd0;
    localparam logic [1:0] S_DECODE  = 2'd1;
    localparam logic [1:0] S_EXECUTE = 2'd2;
    localparam logic [1:0] S_HALT    = 2'd3;

    localparam logic [3:0] OP_REG   = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_BCOND = 4'b1100;

    localparam logic [15:0]         HALT_WORD = 16'hFFFF;
    localparam logic [PC_WIDTH-1:0] PC_ONE    = PC_WIDTH'(1);

    logic [1:0]          state;
    logic [PC_WIDTH-1:0] pc;
    logic [15:0]         ir;

    // Instruction fields
    logic [3:0] op, rd, ext, rs;
    logic [7:0] imm8;
    assign op   = ir[15:12];
    assign rd   = ir[11:8];
    assign ext  = ir[7:4];
    assign rs   = ir[3:0];
    assign imm8 = ir[7:0];

    // L and F are not used by any branch condition.
    logic unused_flags;
    assign unused_flags = ^I_STATUS_FLAGS[2:1];

    logic flag_c, flag_z, flag_n;
    assign flag_c = I_STATUS_FLAGS[0];
    assign flag_z = I_STATUS_FLAGS[3];
    assign flag_n = I_STATUS_FLAGS[4];

    logic in_execute;
    logic is_halt;
    assign in_execute = (state == S_EXECUTE);
    assign is_halt    = (ir == HALT_WORD);

    // Branch condition, selected by the rd field of a Bcond instruction.
    logic cond_true;
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        cond_true = 1'b0;
        case (rd)
            4'd0:    cond_true = flag_z;
            4'd1:    cond_true = ~flag_z;
            4'd2:    cond_true = flag_c;
            4'd3:    cond_true = ~flag_c;
            4'd4:    cond_true = flag_n;
            4'd5:    cond_true = ~flag_n;
            4'd14:   cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // Displacement is sign-extended to the PC width so backward branches
    // and wrap-around both fall out of plain modulo addition.
    logic [PC_WIDTH-1:0] pc_disp;
    logic [PC_WIDTH-1:0] pc_next;
    assign pc_disp = {{(PC_WIDTH-8){imm8[7]}}, imm8};
    assign pc_next = (op == OP_BCOND && cond_true) ? (pc + pc_disp) : (pc + PC_ONE);

    // Datapath controls, decoded from IR; all zero outside EXECUTE.
    logic do_write;
    always_comb begin
        do_write           = 1'b0;
        O_REG_A_SELECT     = 4'd0;
        O_REG_B_SELECT     = 4'd0;
        O_OPCODE           = 4'd0;
        O_IMMEDIATE        = 16'd0;
        O_IMMEDIATE_SELECT = 1'b0;
        if (in_execute && !is_halt) begin
            case (op)
                OP_REG: begin
                    do_write       = 1'b1;
                    O_OPCODE       = ext;
                    O_REG_A_SELECT = rd;
                    O_REG_B_SELECT = rs;
                end
                OP_ADDI: begin
                    do_write           = 1'b1;
                    O_OPCODE           = ALU_ADD;
                    O_REG_A_SELECT     = rd;
                    O_IMMEDIATE        = {{8{imm8[7]}}, imm8};
                    O_IMMEDIATE_SELECT = 1'b1;
                end
                OP_MOVI: begin
                    do_write           = 1'b1;
                    O_OPCODE           = ALU_PASSB;
                    O_IMMEDIATE        = {8'd0, imm8};
                    O_IMMEDIATE_SELECT = 1'b1;
                end
                default: ;  // Bcond and NOPs issue no datapath operation
            endcase
        end
    end

    // The write is gated by the enable so a stalled EXECUTE never writes;
    // it fires on the single edge where EXECUTE is finally left.
    assign O_REG_WRITE_ENABLE = (do_write && I_ENABLE) ? (16'd1 << rd) : 16'd0;

    // Reset gating keeps the strobe low while reset is held even though
    // the reset state is FETCH.
    assign O_MEM_READ = I_NRESET && I_ENABLE && (state == S_FETCH);
    assign O_PC       = pc;
    assign O_HALTED   = (state == S_HALT);

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            // NOTE: state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= 16'd0;
        end else if (I_ENABLE) begin
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    ir    <= I_INSTRUCTION;
                    state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (is_halt) begin
                        state <= S_HALT;   // PC stays at the halt address
                    end else begin
                        pc    <= pc_next;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_HALT;  // HALT is terminal until reset
            endcase
        end
    end

endmodule

// File: tb/tb_cr16_controller.sv
// Self-checking bench for cr16_controller: a table of single-instruction
// vectors (each run from reset at PC 0) plus hand-written sequences for
// the branch loop, enable stall, mid-EXECUTE reset and halt.
module tb_cr16_controller;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] instr;
    logic [4:0]  flags;
    logic [15:0] pc;
    logic        mem_read;
    logic [15:0] we;
    logic [3:0]  a_sel, b_sel, opc;
    logic [15:0] imm;
    logic        isel;
    logic        halted;

    cr16_controller dut (
        .I_CLK              (clk),
        .I_NRESET           (rst_n),
        .I_ENABLE           (en),
        .I_INSTRUCTION      (instr),
        .I_STATUS_FLAGS     (flags),
        .O_PC               (pc),
        .O_MEM_READ         (mem_read),
        .O_REG_WRITE_ENABLE (we),
        .O_REG_A_SELECT     (a_sel),
        .O_REG_B_SELECT     (b_sel),
        .O_OPCODE           (opc),
        .O_IMMEDIATE        (imm),
        .O_IMMEDIATE_SELECT (isel),
        .O_HALTED           (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory, one-cycle read latency.
    logic [15:0] mem [256];
    always @(posedge clk) if (mem_read) instr <= mem[pc[7:0]];

    // Counts clock edges on which a register write is actually presented.
    int wr_edges = 0;
    always @(posedge clk) if (we != 16'd0) wr_edges = wr_edges + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Assumes the caller is in reset; releases it just after a falling edge
    // and returns 1ns later, inside the first FETCH cycle.
    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // From a FETCH sample point, checks the fetch and advances to EXECUTE.
    task automatic to_execute(input logic [15:0] exp_pc, input string tag);
        check({tag, " fetch pc"}, pc, exp_pc);
        check({tag, " mem_read"}, mem_read, 1'b1);
        @(negedge clk);
        check({tag, " decode we"}, we, 16'h0);
        @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] ins;
        logic [4:0]  fl;
        logic [15:0] we;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  op;
        logic [15:0] imm;
        logic        isel;
        logic [4:0]  chk;      // [0]=a [1]=b [2]=op [3]=imm [4]=isel
        logic [15:0] next_pc;
    } vec_t;

    vec_t vecs[22];
    int   base;

    initial begin
        //            ins       flags     we        a     b     op    imm       isel  chk       next pc
        vecs[0]  = '{16'hD105, 5'b00000, 16'h0002, 4'h0, 4'h0, 4'hD, 16'h0005, 1'b1, 5'b11100, 16'h0001};
        vecs[1]  = '{16'h0251, 5'b00000, 16'h0004, 4'h2, 4'h1, 4'h5, 16'h0000, 1'b0, 5'b10111, 16'h0001};
        vecs[2]  = '{16'h0FA7, 5'b00000, 16'h8000, 4'hF, 4'h7, 4'hA, 16'h0000, 1'b0, 5'b10111, 16'h0001};
        vecs[3]  = '{16'h53FF, 5'b00000, 16'h0008, 4'h3, 4'h0, 4'h5, 16'hFFFF, 1'b1, 5'b11101, 16'h0001};
        vecs[4]  = '{16'h5E80, 5'b00000, 16'h4000, 4'hE, 4'h0, 4'h5, 16'hFF80, 1'b1, 5'b11101, 16'h0001};
        vecs[5]  = '{16'h5A7F, 5'b00000, 16'h0400, 4'hA, 4'h0, 4'h5, 16'h007F, 1'b1, 5'b11101, 16'h0001};
        vecs[6]  = '{16'hDBFF, 5'b00000, 16'h0800, 4'h0, 4'h0, 4'hD, 16'h00FF, 1'b1, 5'b11100, 16'h0001};
        vecs[7]  = '{16'hC003, 5'b01000, 16'h0000, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 5'b00000, 16'h0003};
        vecs[8]  = '{16'hC003, 5'b00000, 16'h0000, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 5'b00000, 16'h0001};
        vecs[9]  = '{16'hC1FE, 5'b00000, 16'h0000, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 5'b00000, 16'hFFFE};
        vecs[10] = '{16'hC1FE, 5'b01000, 16'h0000, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 5'b00000, 16'h0001};
        vecs[11] = '{16'hC205, 5'b00001, 16'h0000, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 5'b00000, 16'h0005};
        vecs[12] = '{16'hC305, 5'b00001, 16'h0000, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 5'b00000, 16'h0001};
        vecs[13] = '{16'hC305, 5'b00000, 16'h0000, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 5'b00000, 16'h0005};
        vecs[14] = '{16'hC405, 5'b10000, 16'h0000, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 5'b00000, 16'h0005};
        vecs[15] = '{16'hC505, 5'b10000, 16'h0000, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 5'b00000, 16'h0001};
        vecs[16] = '{16'hCE7F, 5'b00000, 16'h0000, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 5'b00000, 16'h007F};
        vecs[17] = '{16'hC605, 5'b11111, 16'h0000, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 5'b00000, 16'h0001};
        vecs[18] = '{16'hCF05, 5'b11111, 16'h0000, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 5'b00000, 16'h0001};
        vecs[19] = '{16'h7123, 5'b00000, 16'h0000, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 5'b00000, 16'h0001};
        vecs[20] = '{16'hF000, 5'b00000, 16'h0000, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 5'b00000, 16'h0001};
        vecs[21] = '{16'hC080, 5'b01000, 16'h0000, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b0, 5'b00000, 16'hFF80};

        for (int i = 0; i < 256; i++) mem[i] = 16'h1000;   // NOP filler
        rst_n = 1'b0;
        en    = 1'b1;
        flags = 5'b0;
        instr = 16'h0;

        // Reset state
        #1;
        check("rst pc", pc, 16'h0);
        check("rst mem_read", mem_read, 1'b0);
        check("rst we", we, 16'h0);
        check("rst opcode", opc, 4'h0);
        check("rst imm", imm, 16'h0);
        check("rst isel", isel, 1'b0);
        check("rst a", a_sel, 4'h0);
        check("rst b", b_sel, 4'h0);
        check("rst halted", halted, 1'b0);

        // Single-instruction vectors, each from reset at PC 0
        for (int i = 0; i < 22; i++) begin
            rst_n  = 1'b0;
            mem[0] = vecs[i].ins;
            flags  = vecs[i].fl;
            release_reset();
            to_execute(16'h0, $sformatf("v%0d", i));
            check($sformatf("v%0d we", i), we, vecs[i].we);
            check($sformatf("v%0d halted", i), halted, 1'b0);
            if (vecs[i].chk[0]) check($sformatf("v%0d a_sel", i), a_sel, vecs[i].a);
            if (vecs[i].chk[1]) check($sformatf("v%0d b_sel", i), b_sel, vecs[i].b);
            if (vecs[i].chk[2]) check($sformatf("v%0d opcode", i), opc, vecs[i].op);
            if (vecs[i].chk[3]) check($sformatf("v%0d imm", i), imm, vecs[i].imm);
            if (vecs[i].chk[4]) check($sformatf("v%0d isel", i), isel, vecs[i].isel);
            @(negedge clk);
            check($sformatf("v%0d next pc", i), pc, vecs[i].next_pc);
            check($sformatf("v%0d next mem_read", i), mem_read, 1'b1);
            check($sformatf("v%0d next we", i), we, 16'h0);
        end

        // Reset in the middle of EXECUTE: write enable drops at once
        rst_n  = 1'b0;
        mem[0] = 16'hD105;
        release_reset();
        to_execute(16'h0, "mid");
        check("mid we before", we, 16'h0002);
        base = wr_edges;
        #2 rst_n = 1'b0;
        #1;
        check("mid we after rst", we, 16'h0);
        check("mid pc after rst", pc, 16'h0);
        @(negedge clk);
        check("mid no write edge", wr_edges - base, 0);

        // Program: loop through BEQ, stall in EXECUTE, then halt
        mem[0] = 16'hD001;  // MOVI r0,1
        mem[1] = 16'hD101;  // MOVI r1,1
        mem[2] = 16'h0251;  // ADD  r2,r1
        mem[3] = 16'h1000;  // NOP
        mem[4] = 16'hC0FE;  // BEQ  -2
        mem[5] = 16'h53FF;  // ADDI r3,-1
        mem[6] = 16'h1000;  // NOP
        mem[7] = 16'hFFFF;  // HALT
        flags  = 5'b01000;
        release_reset();
        to_execute(16'd0, "p0"); check("p0 we", we, 16'h0001); @(negedge clk);
        to_execute(16'd1, "p1"); check("p1 we", we, 16'h0002); @(negedge clk);
        to_execute(16'd2, "p2");
        check("p2 a_sel", a_sel, 4'h2);
        check("p2 b_sel", b_sel, 4'h1);
        check("p2 opcode", opc, 4'h5);
        check("p2 isel", isel, 1'b0);
        check("p2 we", we, 16'h0004);
        @(negedge clk);
        to_execute(16'd3, "p3"); check("p3 we", we, 16'h0); @(negedge clk);
        to_execute(16'd4, "beq taken"); check("beq taken we", we, 16'h0); @(negedge clk);
        to_execute(16'd2, "p2 again"); check("p2 again we", we, 16'h0004); @(negedge clk);
        to_execute(16'd3, "p3 again"); @(negedge clk);
        flags = 5'b00000;
        to_execute(16'd4, "beq not taken"); check("beq not taken we", we, 16'h0); @(negedge clk);

        // Enable stall during EXECUTE of ADDI r3,-1
        to_execute(16'd5, "stall");
        check("stall imm", imm, 16'hFFFF);
        check("stall we pre", we, 16'h0008);
        base = wr_edges;
        en = 1'b0;
        #1;
        check("stall we off", we, 16'h0);
        check("stall mem_read off", mem_read, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d we", k), we, 16'h0);
            check($sformatf("stall%0d pc", k), pc, 16'd5);
        end
        en = 1'b1;
        #1;
        check("stall we resumed", we, 16'h0008);
        @(negedge clk);
        check("stall write count", wr_edges - base, 1);

        to_execute(16'd6, "p6"); @(negedge clk);
        to_execute(16'd7, "halt"); check("halt exec we", we, 16'h0); @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            check($sformatf("halt%0d halted", k), halted, 1'b1);
            check($sformatf("halt%0d pc", k), pc, 16'd7);
            check($sformatf("halt%0d mem_read", k), mem_read, 1'b0);
            check($sformatf("halt%0d we", k), we, 16'h0);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        check("halt rst halted", halted, 1'b0);
        check("halt rst pc", pc, 16'h0);
        check("halt rst mem_read", mem_read, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
